// File: rtl/comp_vacc_readout_ctrl.sv
// comp_vacc_readout_ctrl: tracks the accumulator write phase and sweeps every antenna pair (a<=b) of each completed buffer half,
// with sideband valid/index/framing delayed to line up with the accumulator's registered outputs.
module comp_vacc_readout_ctrl #(
  parameter int ACC_LEN_BITS = 8,
  parameter int VECTOR_LENGTH = 32,
  parameter int RD_LATENCY = 2,
  localparam int VB = $clog2(VECTOR_LENGTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sync,
  input  logic          dump_en,
  output logic [VB-1:0] ant_sel_a,
  output logic [VB-1:0] ant_sel_b,
  output logic          buf_sel,
  output logic          out_valid,
  output logic [VB-1:0] out_ant_a,
  output logic [VB-1:0] out_ant_b,
  output logic          out_first,
  output logic          out_last,
  output logic          busy,
  output logic          overrun
);
  localparam int WW = ACC_LEN_BITS + VB + 1;
  localparam logic [VB-1:0] LAST = VB'(VECTOR_LENGTH - 1);
  typedef enum logic {IDLE, READ} state_t;
  state_t state;
  logic [WW-1:0] wc;
  logic buf_done;
  logic [RD_LATENCY-1:0] pv, pf, pl;
  logic [RD_LATENCY-1:0][VB-1:0] pa, pb;
  assign buf_done = &wc[WW-2:0] && !sync;
  assign busy = state == READ;
  assign out_valid = pv[RD_LATENCY-1];
  assign out_first = pf[RD_LATENCY-1];
  assign out_last = pl[RD_LATENCY-1];
  assign out_ant_a = pa[RD_LATENCY-1];
  assign out_ant_b = pb[RD_LATENCY-1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wc <= '0;
      ant_sel_a <= '0;
      ant_sel_b <= '0;
      buf_sel <= 1'b0;
      overrun <= 1'b0;
    end else begin
      wc <= sync ? '0 : wc + 1'b1;
      if (sync) state <= IDLE;
      else if (buf_done) begin
        if (state == READ) overrun <= 1'b1;
        state <= dump_en ? READ : IDLE;
        if (dump_en) begin
          ant_sel_a <= '0;
          ant_sel_b <= '0;
          buf_sel <= wc[WW-1];
        end
      end else if (state == READ) begin
        if (ant_sel_b != LAST) ant_sel_b <= ant_sel_b + 1'b1;
        else if (ant_sel_a == LAST) state <= IDLE;
        else begin
          ant_sel_a <= ant_sel_a + 1'b1;
          ant_sel_b <= ant_sel_a + 1'b1;
        end
      end
    end
  end
  // Indices flow freely; only the valid/framing bits are dropped on sync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      pf <= '0;
      pl <= '0;
      pa <= '0;
      pb <= '0;
    end else begin
      pa[0] <= ant_sel_a;
      pb[0] <= ant_sel_b;
      pv[0] <= busy && !sync;
      pf[0] <= busy && !sync && ant_sel_a == '0 && ant_sel_b == '0;
      pl[0] <= busy && !sync && ant_sel_a == LAST && ant_sel_b == LAST;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
        pv[i] <= pv[i-1] && !sync;
        pf[i] <= pf[i-1] && !sync;
        pl[i] <= pl[i-1] && !sync;
      end
    end
  end
endmodule
